// File: rtl/cpu_pkg.sv
// Shared CPU definitions: FSM state codes and multiplier encodings.
// Consumed by the multiplier slice and its bench.
package cpu_pkg;

    localparam int MULT_WIDTH = 32;

    localparam logic [3:0] S_MULT = 4'd13;
    localparam logic [3:0] S_MFLO = 4'd14;

    typedef enum logic [1:0] {
        MULT_IDLE = 2'd0,
        MULT_RUN  = 2'd1,
        MULT_DONE = 2'd2
    } mult_state_t;

    function automatic logic is_mult_start(input logic [3:0] fsm_state);
        return fsm_state == S_MULT;
    endfunction

endpackage

// File: rtl/mult_unit_if.sv
// Multiplier request/result bundle between the CPU FSM and mult_unit.
// master = FSM side, slave = multiplier side.
interface mult_unit_if #(
    parameter int WIDTH = cpu_pkg::MULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output start, A, B,
        input  busy, done, HI, LO
    );

    modport slave (
        input  start, A, B,
        output busy, done, HI, LO
    );
endinterface

// File: rtl/mult_shift_add.sv
// Shift-add datapath: multiplicand, accumulator, adder and multiplier shifter.
// One partial product per step; {acc, mplier} is the running product.
module mult_shift_add #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   mcand_in,
    input  logic [WIDTH-1:0]   mplier_in,
    output logic [2*WIDTH-1:0] product
);
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH:0]   sum;

    assign sum = {1'b0, acc}
               + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};

    // {carry, acc, mplier} >> 1: the sum LSB drops into the multiplier register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
        end else if (load) begin
            mcand  <= mcand_in;
            acc    <= '0;
            mplier <= mplier_in;
        end else if (step) begin
            acc    <= sum[WIDTH:1];
            mplier <= {sum[0], mplier[WIDTH-1:1]};
        end
    end

    assign product = {acc, mplier};

endmodule

// File: rtl/mult_unit.sv
// Sequential multiplier for the multi-cycle CPU: WIDTH+1 cycles start->HI/LO.
// Define MULT_SIGNED_EN for signed (mult) semantics; default is multu.
module mult_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input logic        clk,
    input logic        reset,
    mult_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    mult_state_t        state;
    mult_state_t        state_nxt;
    logic [CW-1:0]      count;
    logic               load;
    logic               step;
    logic [WIDTH-1:0]   mcand_in;
    logic [WIDTH-1:0]   mplier_in;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] result;
    logic               done;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;

`ifdef MULT_SIGNED_EN
    logic sign;

    assign mcand_in  = bus.A[WIDTH-1] ? -bus.A : bus.A;
    assign mplier_in = bus.B[WIDTH-1] ? -bus.B : bus.B;
    assign result    = sign ? -product : product;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sign <= 1'b0;
        end else if (load) begin
            sign <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
        end
    end
`else
    assign mcand_in  = bus.A;
    assign mplier_in = bus.B;
    assign result    = product;
`endif

    mult_shift_add #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .step     (step),
        .mcand_in (mcand_in),
        .mplier_in(mplier_in),
        .product  (product)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        unique case (state)
            MULT_IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = MULT_RUN;
                end
            end
            MULT_RUN: begin
                step = 1'b1;
                if (count == CW'(WIDTH - 1)) begin
                    state_nxt = MULT_DONE;
                end
            end
            MULT_DONE: begin
                state_nxt = MULT_IDLE;
            end
            default: begin
                state_nxt = MULT_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= MULT_IDLE;
            count <= '0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_nxt;
            done  <= (state == MULT_DONE);
            if (load) begin
                count <= '0;
            end else if (step) begin
                count <= count + 1'b1;
            end
            if (state == MULT_DONE) begin
                {hi, lo} <= result;
            end
        end
    end

    assign bus.busy = (state != MULT_IDLE);
    assign bus.done = done;
    assign bus.HI   = hi;
    assign bus.LO   = lo;

endmodule

// File: tb/tb_mult_unit.sv
// Bench for mult_unit: directed corner cases plus random operands
// checked against a plain-arithmetic product model.
module tb_mult_unit;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] fsm_state;
    int         total  = 0;
    int         passed = 0;

    mult_unit_if #(.WIDTH(32)) bus ();

    assign bus.start = is_mult_start(fsm_state);

    mult_unit #(.WIDTH(32)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] ref_mul(input logic [31:0] a,
                                            input logic [31:0] b);
`ifdef MULT_SIGNED_EN
        longint p;
        p = longint'(signed'(a)) * longint'(signed'(b));
        return p;
`else
        return {32'b0, a} * {32'b0, b};
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one op, scramble operands after acceptance, wait for done.
    task automatic run_op(input string tag, input logic [31:0] a,
                          input logic [31:0] b, output logic [63:0] got);
        int   lat;
        logic busy_ok;
        bus.A     = a;
        bus.B     = b;
        fsm_state = S_MULT;
        tick();
        fsm_state = 4'd0;
        bus.A     = $urandom;
        bus.B     = $urandom;
        check({tag, "_busy_start"}, 64'(bus.busy), 64'd1);
        lat     = 0;
        busy_ok = 1'b1;
        while (!bus.done && lat < 40) begin
            tick();
            lat++;
            if (!bus.done && !bus.busy) busy_ok = 1'b0;
        end
        check({tag, "_latency"}, 64'(lat), 64'd33);
        check({tag, "_busy_run"}, 64'(busy_ok), 64'd1);
        check({tag, "_busy_done"}, 64'(bus.busy), 64'd0);
        got = {bus.HI, bus.LO};
        tick();
        check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
        check({tag, "_hold"}, {bus.HI, bus.LO}, got);
    endtask

    initial begin
        logic [63:0] got;
        logic [31:0] a;
        logic [31:0] b;
        int          pos[$];

        fsm_state = 4'd0;
        bus.A     = '0;
        bus.B     = '0;
        reset     = 1'b1;
        tick();
        tick();
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_hilo", {bus.HI, bus.LO}, 64'd0);
        reset = 1'b0;
        tick();

        run_op("7x6", 32'd7, 32'd6, got);
        check("7x6_result", got, 64'h0000_0000_0000_002A);

        // Reset ten cycles into a run discards it and clears HI/LO
        bus.A     = 32'h1234;
        bus.B     = 32'h5678;
        fsm_state = S_MULT;
        tick();
        fsm_state = 4'd0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_done", 64'(bus.done), 64'd0);
        check("midrst_hilo", {bus.HI, bus.LO}, 64'd0);
        reset = 1'b0;
        tick();
        run_op("2x3", 32'd2, 32'd3, got);
        check("2x3_result", got, 64'd6);

        run_op("neg3x5", 32'hFFFF_FFFD, 32'd5, got);
`ifdef MULT_SIGNED_EN
        check("neg3x5_result", got, 64'hFFFF_FFFF_FFFF_FFF1);
`else
        check("neg3x5_result", got, 64'h0000_0004_FFFF_FFF1);
`endif

        run_op("ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, got);
`ifdef MULT_SIGNED_EN
        check("ones_result", got, 64'h0000_0000_0000_0001);
`else
        check("ones_result", got, 64'hFFFF_FFFE_0000_0001);
`endif

        run_op("min", 32'h8000_0000, 32'h8000_0000, got);
        check("min_result", got, 64'h4000_0000_0000_0000);

        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = $urandom;
            if (i == 0) b = 32'd0;
            if (i == 1) a = 32'h7FFF_FFFF;
            run_op("rand", a, b, got);
            check("rand_result", got, ref_mul(a, b));
        end

        // Start held high: one op per 34 cycles, extra starts ignored
        a         = 32'hDEAD_BEEF;
        b         = 32'h0BAD_F00D;
        bus.A     = a;
        bus.B     = b;
        fsm_state = S_MULT;
        tick();
        for (int i = 1; i <= 101; i++) begin
            tick();
            if (bus.done) pos.push_back(i);
        end
        fsm_state = 4'd0;
        check("held_count", 64'(pos.size()), 64'd3);
        if (pos.size() == 3) begin
            check("held_first", 64'(pos[0]), 64'd33);
            check("held_second", 64'(pos[1]), 64'd67);
            check("held_third", 64'(pos[2]), 64'd101);
        end
        check("held_result", {bus.HI, bus.LO}, ref_mul(a, b));
        tick();
        check("held_idle", 64'(bus.busy), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
